// File: rtl/sm83_irq_pkg.sv
// Shared constants and types for the SM83 interrupt controller.
// The optional request synchronizer is selected with SM83_IRQ_SYNC_EN.
package sm83_irq_pkg;

    typedef logic [7:0] irq_vec_t;

    localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam irq_vec_t IF_UNUSED_MASK = 8'hE0;

    // Ones in the positions of the implemented interrupt sources.
    function automatic irq_vec_t impl_mask(input int num_irq);
        irq_vec_t m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < num_irq) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sm83_irq_edge_det.sv
// Per-bit rising-edge detector for peripheral interrupt requests.
// With SM83_IRQ_SYNC_EN defined, each request first passes a 2-flop synchronizer.
module sm83_irq_edge_det
    import sm83_irq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] req_d;
    logic [WIDTH-1:0] req_q;

`ifdef SM83_IRQ_SYNC_EN
    logic [WIDTH-1:0] sync1_d;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_d;
    logic [WIDTH-1:0] sync2_q;

    always_comb begin
        sync1_d = req_in;
        sync2_d = sync1_q;
    end

    // Synchronizer resets to ones so a line high across reset looks already seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src = sync2_q;
`else
    assign src = req_in;
`endif

    always_comb begin
        req_d = src;
        rise  = src & ~req_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '1;
        end else begin
            req_q <= req_d;
        end
    end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, request latching, ack clearing and MMIO access.
// Build with SM83_IRQ_SYNC_EN to synchronize IRQ_REQ before edge detection.
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR = IE_ADDR_DEF,
    parameter int          NUM_IRQ = 5
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [15:0]        A,
    input  logic [7:0]         D_IN,
    output logic [7:0]         D_OUT,
    output logic               D_OE,
    input  logic               RD,
    input  logic               WR,
    input  logic               MMIO_REQ,
    input  logic [NUM_IRQ-1:0] IRQ_REQ,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic [7:0]         CPU_IRQ_TRIG
);

    localparam irq_vec_t IMPL_MASK   = impl_mask(NUM_IRQ);
    localparam irq_vec_t UNUSED_MASK = ~IMPL_MASK;

    logic [NUM_IRQ-1:0] rise;
    irq_vec_t           rise_vec;

    logic     wr_d,   wr_q;
    irq_vec_t if_d,   if_q;
    irq_vec_t ie_d,   ie_q;
    irq_vec_t trig_d, trig_q;

    logic     wr_strike;
    logic     sel_if;
    logic     sel_ie;
    irq_vec_t set_wr;
    irq_vec_t clr_wr;

    sm83_irq_edge_det #(
        .WIDTH (NUM_IRQ)
    ) u_edge_det (
        .clk    (CLK),
        .rst_n  (nRESET),
        .req_in (IRQ_REQ),
        .rise   (rise)
    );

    assign rise_vec = irq_vec_t'(rise);
    assign sel_if   = (A == IF_ADDR);
    assign sel_ie   = (A == IE_ADDR);

    // MMIO strobes: a write takes effect once, on the first edge WR is seen high
    // with MMIO_REQ; a read is answered combinationally while RD and MMIO_REQ hold.
    always_comb begin
        wr_d      = WR;
        wr_strike = WR & ~wr_q & MMIO_REQ;
        set_wr    = '0;
        clr_wr    = '0;
        if (wr_strike && sel_if) begin
            set_wr = D_IN;
            clr_wr = ~D_IN;
        end
        // A new edge beats ack and write; a write beats ack.
        if_d   = (rise_vec | (if_q & ~CPU_IRQ_ACK & ~clr_wr) | set_wr) & IMPL_MASK;
        ie_d   = (wr_strike && sel_ie) ? D_IN : ie_q;
        trig_d = if_d & ie_d & IMPL_MASK;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_q   <= 1'b0;
            if_q   <= '0;
            ie_q   <= '0;
            trig_q <= '0;
        end else begin
            wr_q   <= wr_d;
            if_q   <= if_d;
            ie_q   <= ie_d;
            trig_q <= trig_d;
        end
    end

    assign CPU_IRQ_TRIG = trig_q;

    always_comb begin
        D_OE  = RD & MMIO_REQ & (sel_if | sel_ie);
        D_OUT = '0;
        if (D_OE) begin
            D_OUT = sel_if ? (UNUSED_MASK | if_q) : ie_q;
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed self-checking bench for sm83_irq_ctrl (either SM83_IRQ_SYNC_EN build).
module tb_sm83_irq_ctrl;

`ifdef SM83_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        nRESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;
    logic [4:0]  IRQ_REQ;
    logic [7:0]  CPU_IRQ_ACK;
    logic [7:0]  CPU_IRQ_TRIG;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rd_data;
    logic       rd_oe;

    sm83_irq_ctrl dut (
        .CLK          (CLK),
        .nRESET       (nRESET),
        .A            (A),
        .D_IN         (D_IN),
        .D_OUT        (D_OUT),
        .D_OE         (D_OE),
        .RD           (RD),
        .WR           (WR),
        .MMIO_REQ     (MMIO_REQ),
        .IRQ_REQ      (IRQ_REQ),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drivers: inputs change 1ns after the rising edge, outputs sampled there too.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic read_reg(input logic [15:0] addr, input logic mreq,
                            output logic [7:0] data, output logic oe);
        A        = addr;
        RD       = 1'b1;
        MMIO_REQ = mreq;
        #1;
        data     = D_OUT;
        oe       = D_OE;
        RD       = 1'b0;
        MMIO_REQ = 1'b0;
        #1;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic mreq, input logic [7:0] data);
        A        = addr;
        D_IN     = data;
        WR       = 1'b1;
        MMIO_REQ = mreq;
        tick(1);
        WR       = 1'b0;
        MMIO_REQ = 1'b0;
        tick(1);
    endtask

    task automatic check_if(input string tag, input logic [7:0] exp);
        read_reg(16'hFF0F, 1'b1, rd_data, rd_oe);
        check({tag, "_oe"}, {7'd0, rd_oe}, 8'h01);
        check(tag, rd_data, exp);
    endtask

    initial begin
        nRESET      = 1'b0;
        A           = 16'h0000;
        D_IN        = 8'h00;
        RD          = 1'b0;
        WR          = 1'b0;
        MMIO_REQ    = 1'b0;
        IRQ_REQ     = 5'b00001;
        CPU_IRQ_ACK = 8'h00;
        tick(2);
        check("rst_trig", CPU_IRQ_TRIG, 8'h00);
        check("rst_dout", D_OUT, 8'h00);
        check("rst_doe", {7'd0, D_OE}, 8'h00);

        // Line high across reset release sets nothing; a fresh rise does.
        nRESET = 1'b1;
        tick(LAT + 2);
        check_if("held_if", 8'hE0);
        IRQ_REQ = 5'b00000;
        tick(LAT + 1);
        IRQ_REQ = 5'b00001;
        tick(LAT);
        check_if("rise_if", 8'hE1);
        check("rise_trig_ie0", CPU_IRQ_TRIG, 8'h00);

        // Clear VBlank, enable bits 0 and 2, raise Timer.
        CPU_IRQ_ACK = 8'h01;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        write_reg(16'hFFFF, 1'b1, 8'h05);
        check("ie_only_trig", CPU_IRQ_TRIG, 8'h00);
        IRQ_REQ = 5'b00101;
        tick(LAT - 1);
        check("timer_early_trig", CPU_IRQ_TRIG, 8'h00);
        tick(1);
        check("timer_trig", CPU_IRQ_TRIG, 8'h04);
        exp_q.push_back(8'hE4);
        exp_q.push_back(8'h05);
        read_reg(16'hFF0F, 1'b1, rd_data, rd_oe);
        check("timer_if", rd_data, exp_q.pop_front());
        read_reg(16'hFFFF, 1'b1, rd_data, rd_oe);
        check("ie_read", rd_data, exp_q.pop_front());

        // Ack clears one bit; ack of an unset bit does nothing.
        write_reg(16'hFFFF, 1'b1, 8'h1F);
        write_reg(16'hFF0F, 1'b1, 8'h05);
        check("if_wr_trig", CPU_IRQ_TRIG, 8'h05);
        CPU_IRQ_ACK = 8'h01;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        check("ack_trig", CPU_IRQ_TRIG, 8'h04);
        check_if("ack_if", 8'hE4);
        CPU_IRQ_ACK = 8'h08;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        check_if("ack_unset_if", 8'hE4);

        // Rise, ack and write-zero on the same edge: the rise wins.
        IRQ_REQ = 5'b00100;
        tick(LAT + 1);
        IRQ_REQ = 5'b00101;
        tick(LAT - 1);
        CPU_IRQ_ACK = 8'h01;
        A           = 16'hFF0F;
        D_IN        = 8'h00;
        WR          = 1'b1;
        MMIO_REQ    = 1'b1;
        tick(1);
        WR          = 1'b0;
        MMIO_REQ    = 1'b0;
        CPU_IRQ_ACK = 8'h00;
        check("same_edge_trig", CPU_IRQ_TRIG, 8'h01);
        check_if("same_edge_if", 8'hE1);
        tick(1);

        // Long WR: one strike only, ack on cycle 2 is not undone by the held write.
        A        = 16'hFF0F;
        D_IN     = 8'h1F;
        WR       = 1'b1;
        MMIO_REQ = 1'b1;
        tick(1);
        check("long_wr_c1_trig", CPU_IRQ_TRIG, 8'h1F);
        CPU_IRQ_ACK = 8'h02;
        tick(1);
        CPU_IRQ_ACK = 8'h00;
        check("long_wr_c2_trig", CPU_IRQ_TRIG, 8'h1D);
        tick(2);
        check("long_wr_c4_trig", CPU_IRQ_TRIG, 8'h1D);
        WR       = 1'b0;
        MMIO_REQ = 1'b0;
        tick(1);
        check_if("long_wr_if", 8'hFD);

        // No response off-address or without MMIO_REQ, and no state change.
        read_reg(16'hFF10, 1'b1, rd_data, rd_oe);
        check("bad_addr_oe", {7'd0, rd_oe}, 8'h00);
        check("bad_addr_dout", rd_data, 8'h00);
        read_reg(16'hFF0F, 1'b0, rd_data, rd_oe);
        check("no_mreq_oe", {7'd0, rd_oe}, 8'h00);
        check("no_mreq_dout", rd_data, 8'h00);
        write_reg(16'hFFFF, 1'b0, 8'h00);
        write_reg(16'hFF10, 1'b1, 8'h00);
        read_reg(16'hFFFF, 1'b1, rd_data, rd_oe);
        check("ie_kept", rd_data, 8'h1F);

        // Asynchronous reset while TRIG is pending.
        write_reg(16'hFF0F, 1'b1, 8'h04);
        check("pre_rst_trig", CPU_IRQ_TRIG, 8'h04);
        nRESET = 1'b0;
        #1;
        check("mid_rst_trig", CPU_IRQ_TRIG, 8'h00);
        check_if("mid_rst_if", 8'hE0);
        read_reg(16'hFFFF, 1'b1, rd_data, rd_oe);
        check("mid_rst_ie", rd_data, 8'h00);
        tick(1);
        nRESET = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
